seg_pair_to_bin: RTL

//  Reads a two-digit seven-segment display and recovers its binary value (0..19).

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg7_to_digit.sv | 39 +++
 rtl/seg_pair_to_bin.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the two-digit seven-segment reader: active-low segment
// patterns {a,b,c,d,e,f,g}, error codes and FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] Seg0     = 7'b0000001;
  localparam logic [6:0] Seg1     = 7'b1001111;
  localparam logic [6:0] Seg2     = 7'b0010010;
  localparam logic [6:0] Seg3     = 7'b0000110;
  localparam logic [6:0] Seg4     = 7'b1001100;
  localparam logic [6:0] Seg5     = 7'b0100100;
  localparam logic [6:0] Seg6     = 7'b0100000;
  localparam logic [6:0] Seg7     = 7'b0001111;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0000100;
  localparam logic [6:0] Seg9Alt  = 7'b0001100;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrTens    = 2'b01;
  localparam logic [1:0] ErrOnes    = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StDecode = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational seven-segment pattern decoder. The tens flavour only accepts
// blank/0/1, since the display never shows a tens digit above 1.
module seg7_to_digit
  import seg_pkg::*;
#(
  parameter bit IsTens = 1'b0
) (
  input  logic [6:0] seg_i,
  output logic       legal_o,
  output logic [3:0] digit_o
);

  always_comb begin
    legal_o = 1'b1;
    digit_o = 4'd0;
    if (IsTens) begin
      unique case (seg_i)
        SegBlank, Seg0: digit_o = 4'd0;
        Seg1:           digit_o = 4'd1;
        default:        legal_o = 1'b0;
      endcase
    end else begin
      unique case (seg_i)
        Seg0:          digit_o = 4'd0;
        Seg1:          digit_o = 4'd1;
        Seg2:          digit_o = 4'd2;
        Seg3:          digit_o = 4'd3;
        Seg4:          digit_o = 4'd4;
        Seg5:          digit_o = 4'd5;
        Seg6:          digit_o = 4'd6;
        Seg7:          digit_o = 4'd7;
        Seg8:          digit_o = 4'd8;
        Seg9, Seg9Alt: digit_o = 4'd9;
        default:       legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/seg_pair_to_bin.sv
// Reads a two-digit active-low seven-segment display once its buses have settled
// and returns the binary value (0..19) with an error code over valid/ready.
module seg_pair_to_bin
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] tens_seg,
  input  logic [6:0] ones_seg,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] value,
  output logic [1:0] err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] StableMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] TmoLast   = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntSat    = {CntW{1'b1}};

  state_e          state_q, state_d;
  logic [13:0]     snap_q, snap_d;
  logic [CntW-1:0] stab_q, stab_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic [4:0]      value_q, value_d;
  logic [1:0]      err_q, err_d;

  logic [13:0] cur_seg;
  logic        in_match;
  logic        tens_legal, ones_legal;
  logic [3:0]  tens_digit, ones_digit;
  logic [4:0]  tens5, ones5, dec_value;

  assign cur_seg  = {tens_seg, ones_seg};
  assign in_match = (cur_seg == snap_q);

  // Decoders see only the frozen snapshot, never the live buses.
  seg7_to_digit #(.IsTens(1'b1)) u_tens (
    .seg_i   (snap_q[13:7]),
    .legal_o (tens_legal),
    .digit_o (tens_digit)
  );

  seg7_to_digit #(.IsTens(1'b0)) u_ones (
    .seg_i   (snap_q[6:0]),
    .legal_o (ones_legal),
    .digit_o (ones_digit)
  );

  assign tens5     = {1'b0, tens_digit};
  assign ones5     = {1'b0, ones_digit};
  assign dec_value = (tens5 << 3) + (tens5 << 1) + ones5;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    value_d = value_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d  = cur_seg;
          stab_d  = CntW'(1);
          tmo_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        tmo_d = (tmo_q == CntSat) ? tmo_q : tmo_q + 1'b1;
        if (in_match) begin
          stab_d = (stab_q == CntSat) ? stab_q : stab_q + 1'b1;
        end else begin
          snap_d = cur_seg;
          stab_d = CntW'(1);
        end
        // Stability wins over timeout when both land on the same edge.
        if (in_match && (stab_q >= StableMax)) begin
          state_d = StDecode;
        end else if (tmo_q >= TmoLast) begin
          err_d   = ErrTimeout;
          value_d = 5'd0;
          state_d = StDone;
        end
      end
      StDecode: begin
        if (!tens_legal) begin
          err_d   = ErrTens;
          value_d = 5'd0;
        end else if (!ones_legal) begin
          err_d   = ErrOnes;
          value_d = 5'd0;
        end else begin
          err_d   = ErrOk;
          value_d = dec_value;
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      stab_q  <= '0;
      tmo_q   <= '0;
      value_q <= '0;
      err_q   <= ErrOk;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign value     = value_q;
  assign err       = err_q;

endmodule
